// File: rtl/toom3_gf2_pkg.sv
// Shared definitions for the three-way split GF(2)[x] multiplier.
// Holds the limb-width and cycle-count helpers, the FSM state type and
// the parameter legality check used at elaboration.
package toom3_gf2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        COMB = 2'd2
    } state_t;

    // Limb width: ceil(w/3)
    function automatic int unsigned limb_w(input int unsigned w);
        return (w + 32'd2) / 32'd3;
    endfunction

    // Accumulation cycles: ceil(k/digit)
    function automatic int unsigned n_cycles(input int unsigned k, input int unsigned digit);
        return (k + digit - 32'd1) / digit;
    endfunction

    // Legal parameter set: w >= 3 and 1 <= digit <= limb width
    function automatic bit cfg_ok(input int unsigned w, input int unsigned digit,
                                  input int unsigned pipe);
        return (w >= 32'd3) && (digit >= 32'd1) && (digit <= limb_w(w)) && (pipe < 32'd65536);
    endfunction

endpackage

// File: rtl/gf2_digit_mac.sv
// One limb-product accumulator: digit-serial carry-less multiply of two
// K-bit limbs. Each enabled cycle it folds in DIGIT bits of a_limb,
// starting at bit idx*DIGIT.
//   clk, rst (async, active-low)
//   clr     : zero the accumulator (has priority over en)
//   en      : accumulate the digit selected by idx
//   idx     : digit index
//   a_limb  : limb whose bits are scanned digit by digit
//   b_limb  : limb shifted and XORed in for each set a bit
//   acc     : running 2K-1 bit product
module gf2_digit_mac #(
    parameter int unsigned K     = 3,
    parameter int unsigned DIGIT = 1,
    parameter int unsigned IDX_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    input  logic [K-1:0]       a_limb,
    input  logic [K-1:0]       b_limb,
    output logic [2*K-2:0]     acc
);

    localparam int unsigned PW = 2 * K - 1;

    int unsigned      shamt;
    logic [DIGIT-1:0] a_dig;
    logic [PW-1:0]    b_base;
    logic [PW-1:0]    partial;

    // Bits of a_limb past K shift in as zero, so a short last digit is padded
    always_comb begin
        shamt   = 32'(idx) * DIGIT;
        a_dig   = DIGIT'(a_limb >> shamt);
        b_base  = PW'(b_limb) << shamt;
        partial = '0;
        for (int t = 0; t < int'(DIGIT); t++) begin
            if (a_dig[t]) begin
                partial = partial ^ (b_base << t);
            end
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ partial;
        end
    end

endmodule

// File: rtl/toom3_gf2_mul_seq.sv
// Sequential three-way split carry-less multiplier over GF(2)[x].
// Operands are latched on an accepted start, nine limb products are
// accumulated digit-serially, recombined, and passed through a PIPE-deep
// output register chain.
//   clk, rst (async, active-low)
//   start : request; taken only while ready=1
//   a, b  : W-bit operand polynomials (bit i = coefficient of x^i)
//   ready : idle, start will be accepted
//   done  : one-cycle pulse, c valid in the same cycle
//   c     : 2W-bit product, held between done pulses
module toom3_gf2_mul_seq
    import toom3_gf2_pkg::*;
#(
    parameter int unsigned W     = 571,
    parameter int unsigned DIGIT = 8,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             ready,
    output logic             done,
    output logic [2*W-1:0]   c
);

    localparam int unsigned K     = limb_w(W);
    localparam int unsigned N     = n_cycles(K, DIGIT);
    localparam int unsigned PW    = 2 * K - 1;
    localparam int unsigned XW    = 6 * K - 1;
    localparam int unsigned CW    = 2 * W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!cfg_ok(W, DIGIT, PIPE)) begin : g_cfg_err
        $error("toom3_gf2_mul_seq: illegal W/DIGIT/PIPE combination");
    end

    state_t           state, state_nx;
    logic             accept_c;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_q, b_q;
    logic [3*K-1:0]   a_ext, b_ext;
    logic [K-1:0]     a_l [3];
    logic [K-1:0]     b_l [3];
    logic [PW-1:0]    prod [3][3];
    logic [PW-1:0]    d_p, e_p, f_p, g_p, h_p;
    logic [XW-1:0]    wide_c;
    logic [CW-1:0]    result_c;
    logic             pipe_v [PIPE+1];
    logic [CW-1:0]    pipe_d [PIPE+1];

    // Next-state logic
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && ready) begin
                    accept_c = 1'b1;
                    state_nx = MUL;
                end
            end
            MUL: begin
                if (cnt == CNT_W'(N - 1)) begin
                    state_nx = COMB;
                end
            end
            COMB:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, digit counter, ready flag and operand latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == IDLE);
            if (accept_c) begin
                cnt <= '0;
                a_q <= a;
                b_q <= b;
            end else if (state == MUL) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Split latched operands into zero-padded K-bit limbs
    always_comb begin
        a_ext = (3 * K)'(a_q);
        b_ext = (3 * K)'(b_q);
        for (int i = 0; i < 3; i++) begin
            a_l[i] = a_ext[i*K +: K];
            b_l[i] = b_ext[i*K +: K];
        end
    end

    // Nine limb-product accumulators: prod[i][j] = a_i * b_j
    for (genvar i = 0; i < 3; i++) begin : g_a
        for (genvar j = 0; j < 3; j++) begin : g_b
            gf2_digit_mac #(
                .K     (K),
                .DIGIT (DIGIT),
                .IDX_W (CNT_W)
            ) u_mac (
                .clk    (clk),
                .rst    (rst),
                .clr    (accept_c),
                .en     (state == MUL),
                .idx    (cnt),
                .a_limb (a_l[i]),
                .b_limb (b_l[j]),
                .acc    (prod[i][j])
            );
        end
    end

    // Recombination; bits above 2W-2 are zero, so the final truncation is lossless
    always_comb begin
        d_p      = prod[2][2];
        e_p      = prod[1][2] ^ prod[2][1];
        f_p      = prod[0][2] ^ prod[1][1] ^ prod[2][0];
        g_p      = prod[0][1] ^ prod[1][0];
        h_p      = prod[0][0];
        wide_c   = XW'(h_p)
                 ^ (XW'(g_p) << K)
                 ^ (XW'(f_p) << (2 * K))
                 ^ (XW'(e_p) << (3 * K))
                 ^ (XW'(d_p) << (4 * K));
        result_c = CW'(wide_c);
    end

    // Output chain; data only moves with its valid bit so c holds between pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s <= int'(PIPE); s++) begin
                pipe_v[s] <= 1'b0;
                pipe_d[s] <= '0;
            end
        end else begin
            pipe_v[0] <= (state == COMB);
            if (state == COMB) begin
                pipe_d[0] <= result_c;
            end
            for (int s = 1; s <= int'(PIPE); s++) begin
                pipe_v[s] <= pipe_v[s-1];
                if (pipe_v[s-1]) begin
                    pipe_d[s] <= pipe_d[s-1];
                end
            end
        end
    end

    assign done = pipe_v[PIPE];
    assign c    = pipe_d[PIPE];

endmodule

// File: tb/tb_toom3_gf2_mul_seq.sv
// Directed bench for toom3_gf2_mul_seq. Three instances cover the small
// configurations (W=9, DIGIT=1/PIPE=0 and DIGIT=2/PIPE=2) and the default
// W=571 configuration, which is also run against a bitwise reference.
module tb_toom3_gf2_mul_seq;

    logic clk;
    logic rst;

    logic          st1, rdy1, done1;
    logic [8:0]    a1, b1;
    logic [17:0]   c1;

    logic          st2, rdy2, done2;
    logic [8:0]    a2, b2;
    logic [17:0]   c2;

    logic          st3, rdy3, done3;
    logic [570:0]  a3, b3;
    logic [1141:0] c3;

    int checks;
    int errors;

    toom3_gf2_mul_seq #(.W(9), .DIGIT(1), .PIPE(0)) u_d1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
        .ready(rdy1), .done(done1), .c(c1)
    );

    toom3_gf2_mul_seq #(.W(9), .DIGIT(2), .PIPE(2)) u_d2 (
        .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2),
        .ready(rdy2), .done(done2), .c(c2)
    );

    toom3_gf2_mul_seq #(.W(571), .DIGIT(8), .PIPE(1)) u_d3 (
        .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3),
        .ready(rdy3), .done(done3), .c(c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1141:0] clmul571(input logic [570:0] x, input logic [570:0] y);
        logic [1141:0] r;
        r = '0;
        for (int i = 0; i < 571; i++) begin
            if (x[i]) r = r ^ (1142'(y) << i);
        end
        return r;
    endfunction

    // Issue one op on the W=9/DIGIT=1 instance; lat=-1 on timeout
    task automatic op_d1(input logic [8:0] xa, input logic [8:0] xb,
                         output int lat, output logic [17:0] res);
        a1 = xa; b1 = xb; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        lat = -1;
        res = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (done1) begin
                lat = cyc;
                res = c1;
                break;
            end
        end
    endtask

    // Issue one op on the W=571 instance; lat=-1 on timeout
    task automatic op_d3(input logic [570:0] xa, input logic [570:0] xb,
                         output int lat, output logic [1141:0] res);
        a3 = xa; b3 = xb; st3 = 1'b1;
        tick();
        st3 = 1'b0;
        a3 = ~xa; b3 = ~xb;
        lat = -1;
        res = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (done3) begin
                lat = cyc;
                res = c3;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        st1 = 0; st2 = 0; st3 = 0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", rdy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b exp 0", done1); end
        checks++; if (c1 !== 18'h0) begin errors++; $display("FAIL reset_c1 got %h exp 0", c1); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready2 got %b exp 1", rdy2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done2 got %b exp 0", done2); end
        checks++; if (c2 !== 18'h0) begin errors++; $display("FAIL reset_c2 got %h exp 0", c2); end
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b exp 1", rdy3); end
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3 got %b exp 0", done3); end
        checks++; if (c3 !== '0) begin errors++; $display("FAIL reset_c3 nonzero exp 0"); end
    endtask

    task automatic test_basic();
        int lat;
        logic [17:0] res;
        op_d1(9'h003, 9'h003, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
        checks++; if (res !== 18'h00005) begin errors++; $display("FAIL basic_c got %h exp 00005", res); end
        tick();
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done1); end
        checks++; if (c1 !== 18'h00005) begin errors++; $display("FAIL basic_c_hold got %h exp 00005", c1); end
    endtask

    task automatic test_limbs();
        int lat;
        logic [17:0] res;
        op_d1(9'h1FF, 9'h001, lat, res);
        checks++; if (res !== 18'h001FF) begin errors++; $display("FAIL limbs_ones_c got %h exp 001ff", res); end
        op_d1(9'h100, 9'h100, lat, res);
        checks++; if (res !== 18'h10000) begin errors++; $display("FAIL limbs_top_c got %h exp 10000", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL limbs_latency got %0d exp 4", lat); end
    endtask

    task automatic test_ignored_start();
        int ndone, dcyc;
        logic [17:0] dval;
        ndone = 0; dcyc = -1; dval = '0;
        a2 = 9'h1FF; b2 = 9'h1FF; st2 = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            st2 = (cyc == 1) || (cyc == 3);
            a2 = 9'(cyc * 37);
            b2 = 9'(cyc * 11 + 1);
            tick();
            if (done2) begin
                ndone++;
                dcyc = cyc;
                dval = c2;
            end
        end
        st2 = 1'b0;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
        checks++; if (dcyc !== 5) begin errors++; $display("FAIL ignore_latency got %0d exp 5", dcyc); end
        checks++; if (dval !== 18'h15555) begin errors++; $display("FAIL ignore_c got %h exp 15555", dval); end
    endtask

    task automatic test_reset_mid();
        int ndone, lat;
        logic [17:0] res;
        a1 = 9'h1FF; b1 = 9'h1FF; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", rdy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done1); end
        checks++; if (c1 !== 18'h0) begin errors++; $display("FAIL midrst_c got %h exp 0", c1); end
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (done1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
        op_d1(9'h005, 9'h006, lat, res);
        checks++; if (res !== 18'h0001E) begin errors++; $display("FAIL midrst_restart_c got %h exp 0001e", res); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_restart_lat got %0d exp 4", lat); end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int dcyc [2];
        logic [17:0] dval [2];
        bit issued;
        ndone = 0; issued = 1'b0;
        dcyc[0] = -1; dcyc[1] = -1; dval[0] = '0; dval[1] = '0;
        a1 = 9'h003; b1 = 9'h003; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (done1) begin
                if (ndone < 2) begin
                    dcyc[ndone] = cyc;
                    dval[ndone] = c1;
                end
                ndone++;
            end
            if (rdy1 && !issued) begin
                a1 = 9'h1FF; b1 = 9'h1FF; st1 = 1'b1;
                issued = 1'b1;
            end else begin
                st1 = 1'b0;
            end
        end
        st1 = 1'b0;
        checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", ndone); end
        checks++; if (dval[0] !== 18'h00005) begin errors++; $display("FAIL b2b_first_c got %h exp 00005", dval[0]); end
        checks++; if (dval[1] !== 18'h15555) begin errors++; $display("FAIL b2b_second_c got %h exp 15555", dval[1]); end
        checks++; if (dcyc[1] - dcyc[0] !== 5) begin errors++; $display("FAIL b2b_spacing got %0d exp 5", dcyc[1] - dcyc[0]); end
    endtask

    task automatic test_wide();
        int lat, fb;
        logic [570:0] xa, xb;
        logic [575:0] t;
        logic [1141:0] res, expv, diff;
        for (int n = 0; n < 1003; n++) begin
            if (n == 0) begin
                xa = '0; xb = '1;
            end else if (n == 1) begin
                xa = '0; xa[570] = 1'b1; xb = xa;
            end else if (n == 2) begin
                xa = '1; xb = 571'd1;
            end else begin
                for (int k = 0; k < 18; k++) t[k*32 +: 32] = $urandom;
                xa = t[570:0];
                for (int k = 0; k < 18; k++) t[k*32 +: 32] = $urandom;
                xb = t[570:0];
            end
            if (n == 1) begin
                expv = '0; expv[1140] = 1'b1;
            end else if (n == 0) begin
                expv = '0;
            end else begin
                expv = clmul571(xa, xb);
            end
            op_d3(xa, xb, lat, res);
            checks++;
            if (lat !== 26) begin
                errors++;
                $display("FAIL wide_latency[%0d] got %0d exp 26", n, lat);
            end
            checks++;
            if (res !== expv) begin
                errors++;
                diff = res ^ expv;
                fb = -1;
                for (int i = 0; i < 1142; i++) begin
                    if (diff[i] && fb < 0) fb = i;
                end
                $display("FAIL wide_c[%0d] first differing bit %0d got %b exp %b", n, fb,
                         (fb >= 0) ? res[fb] : 1'bx, (fb >= 0) ? expv[fb] : 1'bx);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_limbs();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toom3_gf2_mul_seq.md
# toom3_gf2_mul_seq

Parametrised, sequential 3-way-split multiplier over GF(2)[x] (carry-less, XOR accumulation). Each operand is split into three limbs and the nine limb products are computed in parallel with digit-serial shift-and-XOR accumulators. The products are recombined into the full 2W-bit result. The block adds a start/ready/done handshake, a configurable digit size and a configurable output pipeline to the fixed-width, free-running three-way multiplier.

## Interface
- `W`, default 571: operand width in bits; must be ≥ 3.
- `DIGIT`, default 8: a-limb bits consumed per accumulation cycle; 1 ≤ DIGIT ≤ K.
- `PIPE`, default 1: extra output register stages; must be ≥ 0.
- Derived: `K = ceil(W/3)` (limb width); `N = ceil(K/DIGIT)` (accumulation cycles).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a multiplication; accepted only when `ready`=1.
- `a`, in, W: multiplicand polynomial; bit i is the coefficient of x^i.
- `b`, in, W: multiplier polynomial.
- `ready`, out, 1: core idle and able to accept `start`.
- `done`, out, 1: one-cycle pulse; `c` is valid in the same cycle.
- `c`, out, 2W: product a·b over GF(2); bit 2W-1 is always 0.

## Operation
- Limbs: `x0=x[K-1:0]`, `x1=x[2K-1:K]`, `x2=x[W-1:2K]`, with the missing high bits zero-padded to K.
- Limb products are carry-less, each 2K-1 bits wide:
  - d = a2b2
  - e = a1b2 ^ a2b1
  - f = a0b2 ^ a1b1 ^ a2b0
  - g = a0b1 ^ a1b0
  - h = a0b0
- Recombination: c = h ^ (g<<K) ^ (f<<2K) ^ (e<<3K) ^ (d<<4K), truncated to 2W bits. Bits above 2W-2 are zero by construction, so truncation must never drop a set bit.
- FSM states:
  - IDLE: `ready`=1. On start&&ready: latch a and b, clear all nine accumulators, cnt←0, go to MUL.
  - MUL: each cycle, for digit j=cnt, every accumulator XORs in (b-limb << (j·DIGIT+t)) for each t<DIGIT where the a-limb bit j·DIGIT+t is set; bits ≥K are treated as 0. cnt increments. When cnt==N-1, go to COMB.
  - COMB: form d..h and c, load output stage 0 with {valid=1, c}, return to IDLE.
- Output pipeline: a PIPE-deep shift register of {valid, c}; `done` is the final valid bit.
  - `c` holds its last value between done pulses.
  - Valid bits in flight are never dropped or reordered.
- `start` while `ready`=0 is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- Latched operands isolate the computation; changes on a or b after acceptance have no effect.
- Reset, including mid-operation: state→IDLE; accumulators, cnt, the pipeline, `c` and `done` all clear to 0; `ready`=1 once reset is released. An aborted operation produces no `done`.

## Timing
- Edge E0 samples start=1 with ready=1.
- Edges E1..EN perform the MUL cycles.
- Edge EN+1 (COMB) registers the result.
- `done`/`c` are visible after edge EN+1+PIPE. Latency = N+1+PIPE cycles; defaults give N=24, latency 26.
- `ready` is low from after E0 until after EN+1. The next start can be sampled at EN+2, giving an initiation interval of N+2 cycles independent of PIPE.
- Reset values: `ready`=1, `done`=0, `c`=0.
- No combinational path from inputs to outputs.

## Structure
- Package `toom3_gf2_pkg`:
  - functions `limb_w(W)` and `n_cycles(K,DIGIT)`;
  - the FSM state enum {IDLE, MUL, COMB};
  - elaboration-time parameter legality checks.
- Sub-module `gf2_digit_mac`, parameters K and DIGIT: one limb-product accumulator with clear/enable inputs and a digit-index input. It is instantiated nine times.
- Top level holds the FSM, the operand latches, recombination and the output pipeline.

## Test plan
- W=9, DIGIT=1, PIPE=0; a=0x003, b=0x003 → c=0x00005. done is asserted exactly 4 cycles after the start edge (N=3).
- W=9; a=0x1FF, b=0x001 → c=0x001FF. Then a=0x100, b=0x100 → c=0x10000, which exercises the top limb and the zero-padding.
- W=9, DIGIT=2, PIPE=2; a=0x1FF, b=0x1FF → c=0x15555. done after N+1+PIPE=5 cycles. start pulsed again at +1 and +3 cycles is ignored, giving exactly one done.
- Reset mid-operation: assert rst low during cycle 2 of MUL. Required: ready=1, done=0, c=0 immediately; no done follows. A new start then returns the correct product.
- Back-to-back: assert start again the first cycle ready returns. Two done pulses arrive N+2 cycles apart with the correct, in-order results.
- W=571, DIGIT=8, PIPE=1; 1000 random operand pairs checked against a bitwise carry-less reference model. Include corner cases a=0, b=all-ones and a=b=x^570 → c=x^1140.
